// File: rtl/backend_pkg.sv
// Shared backend types: scheduler/execute packets and operand source select codes.
// Packet field widths are fixed here; stage parameters must agree with DEF_XLEN/DEF_PREG_W.
package backend_pkg;

    localparam int DEF_XLEN   = 32;
    localparam int DEF_PREG_W = 6;
    localparam int AREG_W     = 5;
    localparam int OPC_W      = 7;
    localparam int ROB_W      = 6;

    typedef enum logic [1:0] {
        ZERO     = 2'd0,
        REG_FILE = 2'd1,
        FORWARD  = 2'd2
    } fwrd_mux;

    typedef struct packed {
        logic [OPC_W-1:0]      opcode;
        logic [AREG_W-1:0]     dst_areg;
        logic [DEF_PREG_W-1:0] dst_preg;
        logic [DEF_PREG_W-1:0] src1_preg;
        logic [DEF_PREG_W-1:0] src2_preg;
        logic [ROB_W-1:0]      rob_entry_idx;
        logic [DEF_XLEN-1:0]   imm_val;
        logic [DEF_XLEN-1:0]   pc;
        logic                  alu_en;
        logic                  br_taken;
        logic                  instr_valid;
    } disp_packet_t;

    typedef struct packed {
        logic [OPC_W-1:0]      opcode;
        logic [AREG_W-1:0]     dst_areg;
        logic [DEF_PREG_W-1:0] dst_preg;
        logic [DEF_PREG_W-1:0] src1_preg;
        logic [DEF_PREG_W-1:0] src2_preg;
        logic [ROB_W-1:0]      rob_entry_idx;
        logic [DEF_XLEN-1:0]   imm_val;
        logic [DEF_XLEN-1:0]   pc;
        logic                  alu_en;
        logic                  br_taken;
        logic                  instr_valid;
        logic [DEF_XLEN-1:0]   src1_val;
        logic [DEF_XLEN-1:0]   src2_val;
        fwrd_mux               src1_sel;
        fwrd_mux               src2_sel;
    } exec_packet_t;

endpackage

// File: rtl/issue_register_read_if.sv
// Scheduler, register file, bypass and execute signals of the register-read stage.
// master = surrounding pipeline, slave = the register-read stage.
interface issue_register_read_if
    import backend_pkg::*;
#(
    parameter int ISSUE_WIDTH = 2,
    parameter int NUM_FWD     = 3,
    parameter int XLEN        = DEF_XLEN,
    parameter int PREG_W      = DEF_PREG_W
);
    logic                                  flush;
    logic [ISSUE_WIDTH-1:0]                in_valid;
    disp_packet_t [ISSUE_WIDTH-1:0]        in_pkt;
    logic                                  in_ready;
    logic [2*ISSUE_WIDTH-1:0][PREG_W-1:0]  rf_raddr;
    logic [2*ISSUE_WIDTH-1:0][XLEN-1:0]    rf_rdata;
    logic [NUM_FWD-1:0]                    fwd_valid;
    logic [NUM_FWD-1:0][PREG_W-1:0]        fwd_preg;
    logic [NUM_FWD-1:0][XLEN-1:0]          fwd_data;
    logic [ISSUE_WIDTH-1:0]                out_valid;
    exec_packet_t [ISSUE_WIDTH-1:0]        out_pkt;
    logic                                  out_ready;

    modport master (
        output flush, in_valid, in_pkt, rf_rdata, fwd_valid, fwd_preg, fwd_data, out_ready,
        input  in_ready, rf_raddr, out_valid, out_pkt
    );

    modport slave (
        input  flush, in_valid, in_pkt, rf_rdata, fwd_valid, fwd_preg, fwd_data, out_ready,
        output in_ready, rf_raddr, out_valid, out_pkt
    );
endinterface

// File: rtl/operand_bypass_mux.sv
// Resolves one source operand: preg 0 reads as zero, else lowest-index matching bypass, else RF.
// Purely combinational, no flow control.
module operand_bypass_mux
    import backend_pkg::*;
#(
    parameter int NUM_FWD = 3,
    parameter int XLEN    = DEF_XLEN,
    parameter int PREG_W  = DEF_PREG_W
) (
    input  logic [PREG_W-1:0]               preg,
    input  logic [XLEN-1:0]                 rf_val,
    input  logic [NUM_FWD-1:0]              fwd_valid,
    input  logic [NUM_FWD-1:0][PREG_W-1:0]  fwd_preg,
    input  logic [NUM_FWD-1:0][XLEN-1:0]    fwd_data,
    output logic [XLEN-1:0]                 val,
    output fwrd_mux                         sel
);
    always_comb begin
        val = rf_val;
        sel = REG_FILE;
        // Scan from the lowest-priority bus so bus 0 wins by overwriting last.
        for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if (fwd_valid[k] && (fwd_preg[k] == preg)) begin
                val = fwd_data[k];
                sel = FORWARD;
            end
        end
        if (preg == '0) begin
            val = '0;
            sel = ZERO;
        end
    end
endmodule

// File: rtl/issue_register_read.sv
// Register-read stage: resolves operands at accept and registers execute packets, 1-cycle latency.
// OUT register plus one skid bundle; in_ready depends only on skid occupancy.
module issue_register_read
    import backend_pkg::*;
#(
    parameter int ISSUE_WIDTH = 2,
    parameter int NUM_FWD     = 3,
    parameter int XLEN        = DEF_XLEN,
    parameter int PREG_W      = DEF_PREG_W
) (
    input  logic                  clk,
    input  logic                  rst,
    issue_register_read_if.slave  io
);
    logic                           out_full;
    logic                           skid_full;
    logic [ISSUE_WIDTH-1:0]         out_valid_q;
    logic [ISSUE_WIDTH-1:0]         skid_valid_q;
    exec_packet_t [ISSUE_WIDTH-1:0] out_pkt_q;
    exec_packet_t [ISSUE_WIDTH-1:0] skid_pkt_q;
    exec_packet_t [ISSUE_WIDTH-1:0] new_pkt;
    logic [XLEN-1:0]                opnd_val [2*ISSUE_WIDTH];
    fwrd_mux                        opnd_sel [2*ISSUE_WIDTH];
    logic                           accept;

    for (genvar i = 0; i < ISSUE_WIDTH; i++) begin : g_lane
        for (genvar s = 0; s < 2; s++) begin : g_src
            logic [PREG_W-1:0] preg;
            assign preg = (s == 0) ? io.in_pkt[i].src1_preg : io.in_pkt[i].src2_preg;
            assign io.rf_raddr[2*i+s] = preg;

            operand_bypass_mux #(
                .NUM_FWD (NUM_FWD),
                .XLEN    (XLEN),
                .PREG_W  (PREG_W)
            ) u_mux (
                .preg      (preg),
                .rf_val    (io.rf_rdata[2*i+s]),
                .fwd_valid (io.fwd_valid),
                .fwd_preg  (io.fwd_preg),
                .fwd_data  (io.fwd_data),
                .val       (opnd_val[2*i+s]),
                .sel       (opnd_sel[2*i+s])
            );
        end
    end

    always_comb begin
        new_pkt = '0;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            new_pkt[i].opcode        = io.in_pkt[i].opcode;
            new_pkt[i].dst_areg      = io.in_pkt[i].dst_areg;
            new_pkt[i].dst_preg      = io.in_pkt[i].dst_preg;
            new_pkt[i].src1_preg     = io.in_pkt[i].src1_preg;
            new_pkt[i].src2_preg     = io.in_pkt[i].src2_preg;
            new_pkt[i].rob_entry_idx = io.in_pkt[i].rob_entry_idx;
            new_pkt[i].imm_val       = io.in_pkt[i].imm_val;
            new_pkt[i].pc            = io.in_pkt[i].pc;
            new_pkt[i].alu_en        = io.in_pkt[i].alu_en;
            new_pkt[i].br_taken      = io.in_pkt[i].br_taken;
            new_pkt[i].instr_valid   = io.in_pkt[i].instr_valid;
            new_pkt[i].src1_val      = opnd_val[2*i];
            new_pkt[i].src2_val      = opnd_val[2*i+1];
            new_pkt[i].src1_sel      = opnd_sel[2*i];
            new_pkt[i].src2_sel      = opnd_sel[2*i+1];
        end
    end

    assign io.in_ready  = !skid_full;
    assign accept       = !skid_full && (|io.in_valid) && !io.flush;
    assign io.out_valid = out_valid_q;
    assign io.out_pkt   = out_pkt_q;

    always_ff @(posedge clk) begin
        if (rst || io.flush) begin
            out_full     <= 1'b0;
            skid_full    <= 1'b0;
            out_valid_q  <= '0;
            skid_valid_q <= '0;
            out_pkt_q    <= '0;
            skid_pkt_q   <= '0;
        end else if (!out_full) begin
            if (accept) begin
                out_full    <= 1'b1;
                out_valid_q <= io.in_valid;
                out_pkt_q   <= new_pkt;
            end
        end else if (!skid_full) begin
            if (io.out_ready) begin
                if (accept) begin
                    out_valid_q <= io.in_valid;
                    out_pkt_q   <= new_pkt;
                end else begin
                    out_full    <= 1'b0;
                    out_valid_q <= '0;
                end
            end else if (accept) begin
                // OUT must stay stable while stalled, so the newcomer parks in SKID.
                skid_full    <= 1'b1;
                skid_valid_q <= io.in_valid;
                skid_pkt_q   <= new_pkt;
            end
        end else if (io.out_ready) begin
            skid_full    <= 1'b0;
            skid_valid_q <= '0;
            out_valid_q  <= skid_valid_q;
            out_pkt_q    <= skid_pkt_q;
        end
    end
endmodule
